// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcodes, sequencer FSM encoding and opcode validity check.
// Used by the sequencer, its register file and the ALU model in the bench.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int REG_N  = 4;
    localparam int IDX_W  = $clog2(REG_N);
    localparam int REP_W  = 4;
    localparam int CNT_W  = 16;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR = 3'b101;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return (op <= OP_NOR);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// REG_N x DATA_W register file, two async read ports, one write port; zero latency reads.
// No backpressure: ALU writeback wins over an external load in the same cycle.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RN = REG_N,
    parameter int IW = $clog2(RN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_addr_a,
    input  logic [IW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    input  logic          wb_en,
    input  logic [IW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          ld_en,
    input  logic [IW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    logic [DW-1:0] rf [RN];

    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RN; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end else if (ld_en) begin
            rf[ld_addr] <= ld_data;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external combinational ALU; response valid cmd_rep+2 clocks after accept.
// One command in flight: cmd_ready low from accept until the response handshake completes.
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [IDX_W-1:0]  cmd_rd,
    input  logic [IDX_W-1:0]  cmd_rs1,
    input  logic [IDX_W-1:0]  cmd_rs2,
    input  logic [REP_W-1:0]  cmd_rep,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);

    logic [1:0]        state;
    logic [REP_W-1:0]  rep_cnt;
    logic [IDX_W-1:0]  rd_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              err_q;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic              wb_en;
    logic              ld_gated;

    assign cmd_ready = (state == S_IDLE);
    assign wb_en     = (state == S_ISSUE);
    assign ld_gated  = ld_en && (state == S_IDLE);

    // Reads are combinational, so an accept coinciding with a load sees the old contents.
    alu_regfile #(
        .DW (DATA_W),
        .RN (REG_N)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (cmd_rs1),
        .rd_addr_b (cmd_rs2),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .wb_en     (wb_en),
        .wb_addr   (rd_q),
        .wb_data   (alu_result),
        .ld_en     (ld_gated),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rep_cnt    <= '0;
            rd_q       <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (op_is_valid(cmd_op)) begin
                            alu_a      <= rf_a;
                            alu_b      <= rf_b;
                            alu_opcode <= cmd_op;
                            rep_cnt    <= cmd_rep;
                            rd_q       <= cmd_rd;
                            err_q      <= 1'b0;
                            state      <= S_ISSUE;
                        end else begin
                            // Rejected opcode leaves the ALU ports and register file untouched.
                            res_q  <= '0;
                            zero_q <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    res_q  <= alu_result;
                    zero_q <= alu_zero;
                    if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - REP_W'(1);
                        alu_a   <= alu_result;
                    end else begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= res_q;
                        rsp_zero  <= zero_q;
                        rsp_err   <= err_q;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural combinational ALU attached.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [IDX_W-1:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [REP_W-1:0]  cmd_rep;
    logic              ld_en;
    logic [IDX_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero, rsp_err;
    logic [CNT_W-1:0]  op_count;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt = 0;
    int lat;
    logic [DATA_W-1:0] a_trace  [16];
    logic [OP_W-1:0]   op_trace [16];

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_rep    (cmd_rep),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [IDX_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [IDX_W-1:0] rd,
                         input logic [IDX_W-1:0] rs1, input logic [IDX_W-1:0] rs2,
                         input logic [REP_W-1:0] rep);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rep = rep;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        a_trace[0]  = alu_a;
        op_trace[0] = alu_opcode;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
            if (n < 16) begin
                a_trace[n]  = alu_a;
                op_trace[n] = alu_opcode;
            end
        end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("hs_valid_drop", 32'(rsp_valid), 32'd0);
        chk("hs_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("hs_op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_rep = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        tick();

        // 1: SUB 8-4
        load(2'd0, 8'h08);
        load(2'd1, 8'h04);
        issue(OP_SUB, 2'd2, 2'd0, 2'd1, 4'd0);
        wait_rsp(lat);
        chk("t1_latency", 32'(lat), 32'd2);
        chk("t1_data", 32'(rsp_data), 32'h04);
        chk("t1_zero", 32'(rsp_zero), 32'd0);
        chk("t1_err", 32'(rsp_err), 32'd0);
        chk("t1_r2", 32'(dut.u_rf.rf[2]), 32'h04);
        handshake();

        // 2: ADD accumulate x4
        issue(OP_ADD, 2'd3, 2'd0, 2'd1, 4'd3);
        wait_rsp(lat);
        chk("t2_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_alu_a%0d", i), 32'(a_trace[i]), 32'(8'h08 + 8'(4 * i)));
            chk($sformatf("t2_opc%0d", i), 32'(op_trace[i]), 32'(OP_ADD));
        end
        chk("t2_data", 32'(rsp_data), 32'h18);
        chk("t2_r3", 32'(dut.u_rf.rf[3]), 32'h18);
        handshake();

        // 3: wrap to zero, then NOR
        load(2'd0, 8'hF0);
        load(2'd1, 8'h10);
        issue(OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0);
        wait_rsp(lat);
        chk("t3_wrap_data", 32'(rsp_data), 32'h00);
        chk("t3_wrap_zero", 32'(rsp_zero), 32'd1);
        handshake();
        load(2'd0, 8'h08);
        load(2'd1, 8'h04);
        issue(OP_NOR, 2'd2, 2'd0, 2'd1, 4'd0);
        wait_rsp(lat);
        chk("t3_nor_data", 32'(rsp_data), 32'hF3);
        chk("t3_nor_zero", 32'(rsp_zero), 32'd0);
        handshake();

        // 4: unsupported opcode
        issue(3'b110, 2'd0, 2'd0, 2'd1, 4'd2);
        wait_rsp(lat);
        chk("t4_err", 32'(rsp_err), 32'd1);
        chk("t4_data", 32'(rsp_data), 32'h00);
        chk("t4_zero", 32'(rsp_zero), 32'd1);
        chk("t4_alu_a", 32'(alu_a), 32'h08);
        chk("t4_alu_b", 32'(alu_b), 32'h04);
        chk("t4_alu_opc", 32'(alu_opcode), 32'(OP_NOR));
        chk("t4_r0", 32'(dut.u_rf.rf[0]), 32'h08);
        chk("t4_r2", 32'(dut.u_rf.rf[2]), 32'hF3);
        chk("t4_r3", 32'(dut.u_rf.rf[3]), 32'h18);
        handshake();

        // 5: response stall with a pending command and an ignored load
        issue(OP_XOR, 2'd2, 2'd0, 2'd1, 4'd0);
        wait_rsp(lat);
        cmd_valid = 1'b1; cmd_op = OP_OR; cmd_rd = 2'd3; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_rep = 4'd0;
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_hold_valid%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("t5_hold_data%0d", i), 32'(rsp_data), 32'h0C);
            chk($sformatf("t5_hold_ready%0d", i), 32'(cmd_ready), 32'd0);
        end
        ld_en = 1'b0;
        handshake();
        tick();
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("t5_second_lat", 32'(lat), 32'd2);
        chk("t5_second_data", 32'(rsp_data), 32'h0C);
        chk("t5_r0_kept", 32'(dut.u_rf.rf[0]), 32'h08);
        chk("t5_r2", 32'(dut.u_rf.rf[2]), 32'h0C);
        handshake();

        // 6: reset in the middle of a long accumulate
        issue(OP_ADD, 2'd3, 2'd0, 2'd1, 4'd7);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_alu", 32'({alu_a, alu_b, 5'(alu_opcode)}), 32'd0);
        chk("t6_rsp", 32'({rsp_data, rsp_zero, rsp_err}), 32'd0);
        chk("t6_op_count", 32'(op_count), 32'd0);
        for (int i = 0; i < REG_N; i++) begin
            chk($sformatf("t6_rf%0d", i), 32'(dut.u_rf.rf[i]), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t6_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
